regfile_sync_clr: RTL and testbench



---
 rtl/regfile_sync_clr.sv | 121 ++++++++++++
 tb/tb_regfile_sync_clr.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sync_clr.sv
// regfile_sync_clr -- MIPS32-style general-purpose register file.
//
// DIRECCIONES = 2**S_AD entries of S_DATA bits. There are two combinational
// read ports and one write port that updates on the rising clk edge. After
// reset, a clearing sequencer zeroes every entry, one per clock edge. Ready
// rises when the clear is complete. No memory init file is needed.
//
// Parameters:
//   S_AD     address width (depth is 2**S_AD, not overridable)
//   S_DATA   data width
//   ZERO_REG 1: entry 0 reads as zero and ignores writes
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   ARead1/ARead2  read addresses
//   AWR            write address
//   DataIn         write data
//   WE             write enable, sampled on rising clk
//   DRead1/DRead2  read data (combinational); 0 while clearing
//   Ready          high once the file is in RUN and accepts writes
//
// Optional build macro:
//   REGFILE_BYPASS_EN  forwards DataIn to a read port in the same cycle
//                      when WE is high and AWR matches the read address
//                      (RUN only; the ZERO_REG rule still takes priority).

module regfile_sync_clr #(
  parameter int S_AD     = 5,
  parameter int S_DATA   = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [S_AD-1:0]   ARead1,
  input  logic [S_AD-1:0]   ARead2,
  input  logic [S_AD-1:0]   AWR,
  input  logic [S_DATA-1:0] DataIn,
  input  logic              WE,
  output logic [S_DATA-1:0] DRead1,
  output logic [S_DATA-1:0] DRead2,
  output logic              Ready
);

  localparam int DIRECCIONES = 2 ** S_AD;
  // The last entry is all ones, so the clear counter never needs to wrap.
  localparam logic [S_AD-1:0] LAST_ADDR = '1;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t            state;
  logic [S_AD-1:0]   clr_cnt;
  logic [S_DATA-1:0] Registro [DIRECCIONES];

  logic wr_blocked;
  logic rd_zero1;
  logic rd_zero2;

  always_comb begin
    wr_blocked = (ZERO_REG != 0) && (AWR == '0);
    rd_zero1   = (ZERO_REG != 0) && (ARead1 == '0);
    rd_zero2   = (ZERO_REG != 0) && (ARead2 == '0);
  end

  // The array is deliberately left untouched on a reset edge. It is zeroed
  // afterwards by the clear sequence, one entry per edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      Ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          Registro[clr_cnt] <= '0;
          clr_cnt           <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state <= RUN;
            Ready <= 1'b1;
          end
        end
        RUN: begin
          if (WE && !wr_blocked) begin
            Registro[AWR] <= DataIn;
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

  // Reads are gated by state, so uncleared storage never reaches the outputs.
  always_comb begin
    DRead1 = '0;
    DRead2 = '0;
    if (state == RUN) begin
      if (!rd_zero1) begin
        DRead1 = Registro[ARead1];
`ifdef REGFILE_BYPASS_EN
        if (WE && (AWR == ARead1)) begin
          DRead1 = DataIn;
        end
`endif
      end
      if (!rd_zero2) begin
        DRead2 = Registro[ARead2];
`ifdef REGFILE_BYPASS_EN
        if (WE && (AWR == ARead2)) begin
          DRead2 = DataIn;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_sync_clr.sv
// tb_regfile_sync_clr -- self-checking bench for regfile_sync_clr.
// Two instances share the stimulus: one with ZERO_REG=1 and one with
// ZERO_REG=0. A behavioural model holds the expected array contents and
// Ready status.

module tb_regfile_sync_clr;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        we;
  logic [4:0]  awr;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [31:0] din;
  logic [31:0] d1, d2, e1, e2;
  logic        rdy, rdy0;

  regfile_sync_clr #(.S_AD(5), .S_DATA(32), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .ARead1(a1), .ARead2(a2), .AWR(awr),
    .DataIn(din), .WE(we), .DRead1(d1), .DRead2(d2), .Ready(rdy)
  );

  regfile_sync_clr #(.S_AD(5), .S_DATA(32), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .ARead1(a1), .ARead2(a2), .AWR(awr),
    .DataIn(din), .WE(we), .DRead1(e1), .DRead2(e2), .Ready(rdy0)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Behavioural model: array contents per ZERO_REG flavour, ready flag, and
  // the number of clean edges seen since the last reset.
  logic [31:0] mem1 [32];
  logic [31:0] mem0 [32];
  logic        m_ready = 1'b0;
  int          m_edges = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  awr;
    logic [31:0] din;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] x1;
    logic [31:0] x2;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input bit zr, input logic [4:0] a);
    if (!m_ready) return 32'h0;
    if (zr && a == 5'd0) return 32'h0;
    if (BYP && we && awr == a) return din;
    return zr ? mem1[a] : mem0[a];
  endfunction

  task automatic set_in(input logic r, input logic w, input logic [4:0] aw,
                        input logic [31:0] d, input logic [4:0] x1, input logic [4:0] x2);
    rst = r; we = w; awr = aw; din = d; a1 = x1; a2 = x2;
  endtask

  task automatic check_model();
    check("z1_rd1", d1, model_read(1'b1, a1));
    check("z1_rd2", d2, model_read(1'b1, a2));
    check("z1_rdy", {31'b0, rdy}, {31'b0, m_ready});
    check("z0_rd1", e1, model_read(1'b0, a1));
    check("z0_rd2", e2, model_read(1'b0, a2));
    check("z0_rdy", {31'b0, rdy0}, {31'b0, m_ready});
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (rst) begin
      m_ready = 1'b0;
      m_edges = 0;
      for (int i = 0; i < 32; i++) begin
        mem1[i] = 32'h0;
        mem0[i] = 32'h0;
      end
    end else if (!m_ready) begin
      m_edges++;
      if (m_edges == 32) m_ready = 1'b1;
    end else if (we) begin
      mem0[awr] = din;
      if (awr != 5'd0) mem1[awr] = din;
    end
    @(negedge clk);
  endtask

  task automatic step(input logic r, input logic w, input logic [4:0] aw,
                      input logic [31:0] d, input logic [4:0] x1, input logic [4:0] x2);
    set_in(r, w, aw, d, x1, x2);
    #1;
    check_model();
    clock_edge();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed table, applied on a freshly cleared file.
    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd6,  BYP ? 32'hDEADBEEF : 32'h0, 32'h0};
    tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 5'd0,  32'h0,        5'd6,  5'd5,  32'h0,        32'hDEADBEEF};
    tbl[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    tbl[5] = '{1'b1, 5'd7,  32'h11,       5'd5,  5'd7,  32'hDEADBEEF, BYP ? 32'h11 : 32'h0};
    tbl[6] = '{1'b1, 5'd7,  32'h22,       5'd7,  5'd7,  BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11};
    tbl[7] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h22,       32'h22};
    tbl[8] = '{1'b1, 5'd31, 32'h80000001, 5'd31, 5'd30, BYP ? 32'h80000001 : 32'h0, 32'h0};
    tbl[9] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd0,  32'h80000001, 32'h0};

    // The first edge brings the DUT out of its unknown power-up state.
    set_in(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    clock_edge();
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);

    // Reset sequence, with writes to entry 3 attempted throughout CLEAR.
    for (int i = 0; i < 32; i++) begin
      set_in(1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 5'(i), 5'(31 - i));
      #1;
      check("clr_ready_low", {31'b0, rdy}, 32'h0);
      check("clr_rd1_zero", d1, 32'h0);
      check("clr_rd2_zero", e2, 32'h0);
      check_model();
      clock_edge();
    end
    check("ready_after_32", {31'b0, rdy}, 32'h1);
    for (int i = 0; i < 32; i++) begin
      set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i));
      #1;
      check("cleared_entry", d1, 32'h0);
      check("cleared_entry_z0", e2, 32'h0);
      check_model();
      clock_edge();
    end

    // Table-driven write/read, zero register and same-cycle hazard.
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, tbl[i].we, tbl[i].awr, tbl[i].din, tbl[i].a1, tbl[i].a2);
      #1;
      check("tbl_rd1", d1, tbl[i].x1);
      check("tbl_rd2", d2, tbl[i].x2);
      check("tbl_rdy", {31'b0, rdy}, 32'h1);
      check_model();
      clock_edge();
    end
    // With ZERO_REG=0, entry 0 keeps the value written in the table.
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd3);
    #1;
    check("z0_reg0_stored", e1, 32'hFFFFFFFF);
    check("z1_reg0_zero", d1, 32'h0);
    check("z1_entry3_clear", d2, 32'h0);
    clock_edge();

    // Reset mid-operation: write entry 9, then re-clear it, with a second
    // reset pulse at clr_cnt=10.
    step(1'b0, 1'b1, 5'd9, 32'h1234, 5'd0, 5'd0);
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    #1;
    check("entry9_written", d1, 32'h1234);
    clock_edge();
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    for (int i = 0; i < 32; i++) begin
      set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
      #1;
      check("reclr_ready_low", {31'b0, rdy}, 32'h0);
      check_model();
      clock_edge();
    end
    #1;
    check("reclr_ready_high", {31'b0, rdy}, 32'h1);
    check("entry9_cleared", d1, 32'h0);

    // Randomised traffic with occasional resets; addresses often collide.
    for (int n = 0; n < 600; n++) begin
      logic        r, w;
      logic [4:0]  aw, x1, x2;
      r  = ($urandom_range(0, 79) == 0);
      w  = $urandom_range(0, 1) == 1;
      aw = 5'($urandom_range(0, 31));
      x1 = ($urandom_range(0, 3) == 0) ? aw : 5'($urandom_range(0, 31));
      x2 = ($urandom_range(0, 3) == 0) ? aw : 5'($urandom_range(0, 31));
      step(r, w, aw, $urandom, x1, x2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
